// File: rtl/dwr_stage.sv
// Write-data staging FIFO feeding the data-bus lane replicator.
// Presents the head entry as registered data, replication selects and byte enables.
module dwr_stage #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    output logic        wr_rdy,
    input  logic [63:0] wr_data,
    input  logic [1:0]  wr_siz,
    input  logic [2:0]  wr_a,
    output logic [63:0] din,
    output logic [2:0]  dmuxu,
    output logic [7:0]  ben,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int CW = AW + 1;

    logic [63:0]   r_mem_data [DEPTH];
    logic [1:0]    r_mem_siz  [DEPTH];
    logic [2:0]    r_mem_a    [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_valid;
    logic [63:0]   r_din;
    logic [2:0]    r_dmuxu;
    logic [7:0]    r_ben;

    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic [AW-1:0] w_wr_ptr_next;
    logic [AW-1:0] w_rd_ptr_next;
    logic [CW-1:0] w_count_next;
    logic [63:0]   w_head_data;
    logic [1:0]    w_head_siz;
    logic [2:0]    w_head_a;
    logic [2:0]    w_dmuxu_next;
    logic [7:0]    w_ben_next;

    assign wr_rdy    = (r_count != CW'(DEPTH));
    assign w_push    = wr_req & wr_rdy;
    assign w_pop     = out_ack & r_valid;
    assign w_ovf_set = wr_req & ~wr_rdy;

    assign w_wr_ptr_next = w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
    assign w_rd_ptr_next = w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CW'(1);
    end

    // The next head is the entry being written this edge when it lands on the
    // slot the read pointer is about to point at (empty FIFO, or a
    // single-entry FIFO that pops and pushes together).
    always_comb begin
        w_head_data = r_mem_data[w_rd_ptr_next];
        w_head_siz  = r_mem_siz[w_rd_ptr_next];
        w_head_a    = r_mem_a[w_rd_ptr_next];
        if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_data = wr_data;
            w_head_siz  = wr_siz;
            w_head_a    = wr_a;
        end
    end

    always_comb begin
        w_dmuxu_next = 3'b000;
        w_ben_next   = 8'h00;
        case (w_head_siz)
            2'd0: begin
                w_dmuxu_next = 3'b111;
                w_ben_next   = 8'h01 << w_head_a;
            end
            2'd1: begin
                w_dmuxu_next = 3'b110;
                w_ben_next   = 8'h03 << {w_head_a[2:1], 1'b0};
            end
            2'd2: begin
                w_dmuxu_next = 3'b100;
                w_ben_next   = 8'h0F << {w_head_a[2], 2'b00};
            end
            2'd3: begin
                w_dmuxu_next = 3'b000;
                w_ben_next   = 8'hFF;
            end
            default: begin
                w_dmuxu_next = 3'b000;
                w_ben_next   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= wr_data;
            r_mem_siz[r_wr_ptr]  <= wr_siz;
            r_mem_a[r_wr_ptr]    <= wr_a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_din    <= '0;
            r_dmuxu  <= '0;
            r_ben    <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
            if (w_count_next != '0) begin
                r_valid <= 1'b1;
                r_din   <= w_head_data;
                r_dmuxu <= w_dmuxu_next;
                r_ben   <= w_ben_next;
            end else begin
                r_valid <= 1'b0;
                r_din   <= '0;
                r_dmuxu <= '0;
                r_ben   <= '0;
            end
        end
    end

    assign din       = r_din;
    assign dmuxu     = r_dmuxu;
    assign ben       = r_ben;
    assign out_valid = r_valid;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_dwr_stage.sv
// Self-checking bench for dwr_stage: directed vector table, reset corners,
// streaming, and randomized traffic against a queue-based reference model.
module tb_dwr_stage;

    localparam int DEPTH = 2;
    localparam int AW    = 1;
    localparam int NV    = 12;

    logic        clk;
    logic        reset;
    logic        wr_req;
    logic        wr_rdy;
    logic [63:0] wr_data;
    logic [1:0]  wr_siz;
    logic [2:0]  wr_a;
    logic [63:0] din;
    logic [2:0]  dmuxu;
    logic [7:0]  ben;
    logic        out_valid;
    logic        out_ack;
    logic        ovf;
    logic        ovf_clr;

    dwr_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_rdy    (wr_rdy),
        .wr_data   (wr_data),
        .wr_siz    (wr_siz),
        .wr_a      (wr_a),
        .din       (din),
        .dmuxu     (dmuxu),
        .ben       (ben),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        req;
        logic [63:0] data;
        logic [1:0]  siz;
        logic [2:0]  a;
        logic        ack;
        logic        clr;
        logic        e_valid;
        logic [63:0] e_din;
        logic [2:0]  e_dmuxu;
        logic [7:0]  e_ben;
        logic        e_rdy;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  siz;
        logic [2:0]  a;
    } ent_t;

    vec_t vecs [NV];
    ent_t m_q [$];
    logic m_ovf;
    int   n_pass;
    int   n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference decode: a transfer of 2^siz bytes occupies consecutive lanes
    // starting at the address rounded down to its own size.
    function automatic logic [7:0] m_ben(input logic [1:0] siz, input logic [2:0] a);
        int n;
        int base;
        n    = 1 << siz;
        base = (int'(a) / n) * n;
        return 8'(((1 << n) - 1) << base);
    endfunction

    function automatic logic [2:0] m_dmuxu(input logic [1:0] siz);
        case (siz)
            2'd0:    return 3'b111;
            2'd1:    return 3'b110;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic step(input logic req, input logic [63:0] data, input logic [1:0] siz,
                        input logic [2:0] a, input logic ack, input logic clr);
        bit   rdy_pre;
        ent_t e;
        @(negedge clk);
        wr_req  = req;
        wr_data = data;
        wr_siz  = siz;
        wr_a    = a;
        out_ack = ack;
        ovf_clr = clr;
        @(posedge clk);
        rdy_pre = (m_q.size() != DEPTH);
        if (ack && m_q.size() != 0) void'(m_q.pop_front());
        if (req && rdy_pre) begin
            e.data = data;
            e.siz  = siz;
            e.a    = a;
            m_q.push_back(e);
        end
        if (req && !rdy_pre) m_ovf = 1'b1;
        else if (clr)        m_ovf = 1'b0;
        #1;
    endtask

    task automatic check_model(input string tag);
        if (m_q.size() != 0) begin
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_din"},   din, m_q[0].data);
            chk({tag, "_dmuxu"}, 64'(dmuxu), 64'(m_dmuxu(m_q[0].siz)));
            chk({tag, "_ben"},   64'(ben), 64'(m_ben(m_q[0].siz, m_q[0].a)));
        end else begin
            chk({tag, "_valid"}, 64'(out_valid), 64'd0);
            chk({tag, "_zero"},  {din[63:11], dmuxu, ben}, 64'd0);
        end
        chk({tag, "_rdy"}, 64'(wr_rdy), 64'(m_q.size() != DEPTH));
        chk({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_din"},   din, 64'd0);
        chk({tag, "_dmuxu"}, 64'(dmuxu), 64'd0);
        chk({tag, "_ben"},   64'(ben), 64'd0);
        chk({tag, "_rdy"},   64'(wr_rdy), 64'd1);
        chk({tag, "_ovf"},   64'(ovf), 64'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_ovf   = 1'b0;
        reset   = 1'b0;
        wr_req  = 1'b0;
        wr_data = '0;
        wr_siz  = '0;
        wr_a    = '0;
        out_ack = 1'b0;
        ovf_clr = 1'b0;

        //            req   data          siz   a     ack   clr   valid din           dmuxu   ben    rdy   ovf
        vecs[0]  = '{1'b1, 64'hA5,       2'd0, 3'd5, 1'b0, 1'b0, 1'b1, 64'hA5,       3'b111, 8'h20, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 64'h0,        2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0,        3'b000, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 64'h1111,     2'd1, 3'd3, 1'b0, 1'b0, 1'b1, 64'h1111,     3'b110, 8'h0C, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 64'h2222,     2'd2, 3'd6, 1'b0, 1'b0, 1'b1, 64'h1111,     3'b110, 8'h0C, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 64'h3333,     2'd3, 3'd7, 1'b0, 1'b0, 1'b1, 64'h1111,     3'b110, 8'h0C, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 64'h3333,     2'd3, 3'd7, 1'b1, 1'b0, 1'b1, 64'h2222,     3'b100, 8'hF0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 64'h0,        2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 64'h2222,     3'b100, 8'hF0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 64'h3333,     2'd3, 3'd7, 1'b1, 1'b0, 1'b1, 64'h3333,     3'b000, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 64'h4444,     2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 64'h3333,     3'b000, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 64'h5555,     2'd1, 3'd2, 1'b0, 1'b1, 1'b1, 64'h3333,     3'b000, 8'hFF, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 64'h0,        2'd0, 3'd0, 1'b1, 1'b1, 1'b1, 64'h4444,     3'b111, 8'h01, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 64'h0,        2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0,        3'b000, 8'h00, 1'b1, 1'b0};

        // Reset asserted between clock edges must clear outputs at once.
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("rst_release");

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].req, vecs[i].data, vecs[i].siz, vecs[i].a, vecs[i].ack, vecs[i].clr);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d_din", i),   din, vecs[i].e_din);
            chk($sformatf("vec%0d_dmuxu", i), 64'(dmuxu), 64'(vecs[i].e_dmuxu));
            chk($sformatf("vec%0d_ben", i),   64'(ben), 64'(vecs[i].e_ben));
            chk($sformatf("vec%0d_rdy", i),   64'(wr_rdy), 64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_ovf", i),   64'(ovf), 64'(vecs[i].e_ovf));
        end

        // Streaming: one entry primed, then push and pop together every cycle.
        step(1'b1, 64'h1000, 2'd3, 3'd0, 1'b0, 1'b0);
        check_model("stream_prime");
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 64'h1000 + 64'(i), 2'(i % 4), 3'(i), 1'b1, 1'b0);
            chk($sformatf("stream%0d_din", i),   din, 64'h1000 + 64'(i));
            chk($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("stream%0d_rdy", i),   64'(wr_rdy), 64'd1);
        end
        step(1'b0, 64'h0, 2'd0, 3'd0, 1'b1, 1'b0);
        check_model("stream_drain");

        // Reset with two entries queued and ovf set.
        step(1'b1, 64'hAAAA, 2'd2, 3'd1, 1'b0, 1'b0);
        step(1'b1, 64'hBBBB, 2'd1, 3'd4, 1'b0, 1'b0);
        step(1'b1, 64'hCCCC, 2'd0, 3'd2, 1'b0, 1'b0);
        check_model("full_ovf");
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst_mid");
        m_q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        wr_req = 1'b0;
        step(1'b1, 64'hDEAD_BEEF_0123_4567, 2'd1, 3'd5, 1'b0, 1'b0);
        chk("post_rst_din",   din, 64'hDEAD_BEEF_0123_4567);
        chk("post_rst_ben",   64'(ben), 64'h30);
        chk("post_rst_dmuxu", 64'(dmuxu), 64'(3'b110));
        step(1'b0, 64'h0, 2'd0, 3'd0, 1'b1, 1'b0);
        check_model("post_rst_pop");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 6), {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
